// File: rtl/neuron_timestep_controller.sv
// Timestep sequencer for a LIF neuron: accumulates FP32 weights, drives the potential
// adder through clear/set/decay/evaluate, and captures the resulting potential and spike.
module neuron_timestep_controller #(
    parameter int unsigned DECAY_SHIFT     = 1,
    parameter int unsigned ADDER_WAIT      = 2,
    parameter logic [31:0] RESET_POTENTIAL = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        timestep,
    input  logic        w_valid,
    input  logic [31:0] w_data,
    output logic        w_ready,
    output logic [31:0] input_weight,
    output logic [31:0] decayed_potential,
    output logic        set_adder,
    output logic        clear_adder,
    input  logic [31:0] final_potential,
    input  logic        spike_in,
    output logic [31:0] potential,
    output logic        spike_out,
    output logic        done,
    output logic        overrun
);

    localparam int unsigned CNT_W = (ADDER_WAIT > 1) ? $clog2(ADDER_WAIT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_SET, ST_DECAY, ST_EVAL, ST_CAPTURE, ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        pot_q, pot_d;
    logic [31:0]        in_w_q, in_w_d;
    logic [31:0]        dec_q, dec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               spike_q, spike_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;

    // FP32 add, round-to-nearest-even; subnormals kept, NaN/inf propagated
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [27:0] mx, my, lost, sum;
        logic [24:0] rnd;
        logic        sub, up;
        int          ex, ey, sh;
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex   = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        ey   = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
        mx   = {1'b0, x[30:23] != 8'd0, x[22:0], 3'b000};
        my   = {1'b0, y[30:23] != 8'd0, y[22:0], 3'b000};
        sh   = ex - ey;
        if (sh > 27) sh = 27;
        lost = my & ((28'd1 << sh) - 28'd1);
        my   = (my >> sh) | {27'd0, |lost};
        sub  = x[31] ^ y[31];
        sum  = sub ? (mx - my) : (mx + my);
        if (x[30:23] == 8'hFF) begin
            res = (y[30:23] == 8'hFF && sub && x[22:0] == 23'd0 && y[22:0] == 23'd0)
                  ? 32'h7FC0_0000 : x;
        end else if (sum == 28'd0) begin
            res = 32'h0000_0000;
        end else begin
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                ex  = ex + 1;
            end else begin
                for (int i = 0; i < 26; i++) begin
                    if (!sum[26] && ex > 1) begin
                        sum = sum << 1;
                        ex  = ex - 1;
                    end
                end
            end
            up  = sum[2] & (sum[3] | sum[1] | sum[0]);
            rnd = {1'b0, sum[26:3]} + {24'd0, up};
            if (rnd[24]) begin
                rnd = rnd >> 1;
                ex  = ex + 1;
            end
            if (ex >= 255) res = {x[31], 8'hFF, 23'd0};
            else           res = {x[31], rnd[23] ? 8'(ex) : 8'd0, rnd[22:0]};
        end
        return res;
    endfunction

    // Power-of-two decay by exponent decrement; underflow flushes to +0
    function automatic logic [31:0] decay(input logic [31:0] p);
        logic [31:0] res;
        if (p[30:23] == 8'hFF)                      res = p;
        else if (32'(p[30:23]) <= DECAY_SHIFT)      res = 32'h0000_0000;
        else res = {p[31], p[30:23] - 8'(DECAY_SHIFT), p[22:0]};
        return res;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (timestep || pending_q) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_SET;
            ST_SET:     state_d = ST_DECAY;
            ST_DECAY:   state_d = ST_EVAL;
            ST_EVAL:    if (cnt_q == '0) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    state_d = pending_q ? ST_CLEAR : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready     = (state_q == ST_IDLE);
        clear_adder = (state_q == ST_CLEAR);
        set_adder   = (state_q == ST_SET);
        done        = (state_q == ST_DONE);
        spike_out   = (state_q == ST_DONE) && spike_q;
    end

    always_comb begin
        acc_d     = acc_q;
        pot_d     = pot_q;
        in_w_d    = in_w_q;
        dec_d     = dec_q;
        cnt_d     = cnt_q;
        spike_d   = spike_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (state_q == ST_CAPTURE)      acc_d = 32'h0000_0000;
        else if (w_valid && w_ready)    acc_d = fp_add(acc_q, w_data);

        if (state_q == ST_DECAY) begin
            in_w_d = acc_q;
            dec_d  = decay(pot_q);
            cnt_d  = CNT_W'(ADDER_WAIT - 1);
        end else if (state_q == ST_EVAL && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (state_q == ST_CAPTURE) begin
            pot_d   = final_potential;
            spike_d = spike_in;
        end

        // One queued timestep; a pulse arriving with one already queued is lost
        if (state_q == ST_IDLE) begin
            pending_d = pending_q & timestep;
        end else if (state_q == ST_DONE) begin
            pending_d = timestep;
        end else if (timestep) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q     <= 32'h0000_0000;
            pot_q     <= RESET_POTENTIAL;
            in_w_q    <= 32'h0000_0000;
            dec_q     <= 32'h0000_0000;
            cnt_q     <= '0;
            spike_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            pot_q     <= pot_d;
            in_w_q    <= in_w_d;
            dec_q     <= dec_d;
            cnt_q     <= cnt_d;
            spike_q   <= spike_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign input_weight      = in_w_q;
    assign decayed_potential = dec_q;
    assign potential         = pot_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_neuron_timestep_controller.sv
// Directed bench for neuron_timestep_controller with a behavioural LIF adder
// (threshold 40.0, subtract-on-spike) and a scoreboard of per-timestep results.
module tb_neuron_timestep_controller;

    logic        CLK;
    logic        RESET;
    logic        timestep;
    logic        w_valid;
    logic [31:0] w_data;
    logic        w_ready;
    logic [31:0] input_weight;
    logic [31:0] decayed_potential;
    logic        set_adder;
    logic        clear_adder;
    logic [31:0] final_potential;
    logic        spike_in;
    logic [31:0] potential;
    logic        spike_out;
    logic        done;
    logic        overrun;

    neuron_timestep_controller #(
        .DECAY_SHIFT(1), .ADDER_WAIT(2), .RESET_POTENTIAL(32'h0000_0000)
    ) dut (
        .CLK(CLK), .RESET(RESET), .timestep(timestep),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .input_weight(input_weight), .decayed_potential(decayed_potential),
        .set_adder(set_adder), .clear_adder(clear_adder),
        .final_potential(final_potential), .spike_in(spike_in),
        .potential(potential), .spike_out(spike_out), .done(done), .overrun(overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] iw;
        logic [31:0] dp;
        logic [31:0] pot;
        logic        spk;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    real         acc_m;
    logic [31:0] pot_m;
    logic        ovr_en;
    logic [31:0] ovr_val;
    logic [32:0] adder_out;

    function automatic real fp_to_real(input logic [31:0] b);
        real r;
        int  k;
        if (b[30:23] == 8'd0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        k = int'(b[30:23]) - 127;
        for (int i = 0; i < k; i++) r = r * 2.0;
        for (int i = 0; i > k; i--) r = r / 2.0;
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] real_to_fp(input real r);
        real    a;
        int     e;
        logic   s;
        longint m;
        if (r == 0.0) return 32'h0000_0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = longint'((a - 1.0) * 8388608.0);
        return {s, 8'(e), 23'(m)};
    endfunction

    // LIF adder: spike when sum reaches 40.0, then subtract the threshold
    function automatic logic [32:0] adder_fn(input logic [31:0] dp, input logic [31:0] iw);
        real s;
        if (dp[30:23] == 8'hFF || iw[30:23] == 8'hFF) return {1'b1, 32'h7F80_0000};
        s = fp_to_real(dp) + fp_to_real(iw);
        if (s >= 40.0) return {1'b1, real_to_fp(s - 40.0)};
        return {1'b0, real_to_fp(s)};
    endfunction

    function automatic logic [31:0] decay_m(input logic [31:0] p);
        if (p[30:23] == 8'hFF) return p;
        if (p[30:23] <= 8'd1)  return 32'h0000_0000;
        return real_to_fp(fp_to_real(p) / 2.0);
    endfunction

    always_comb begin
        adder_out       = adder_fn(decayed_potential, input_weight);
        final_potential = ovr_en ? ovr_val : adder_out[31:0];
        spike_in        = ovr_en ? 1'b0 : adder_out[32];
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_expect();
        exp_t e;
        logic [32:0] r;
        e.dp = decay_m(pot_m);
        e.iw = real_to_fp(acc_m);
        if (ovr_en) r = {1'b0, ovr_val};
        else        r = adder_fn(e.dp, e.iw);
        e.spk = r[32];
        e.pot = r[31:0];
        pot_m = e.pot;
        acc_m = 0.0;
        sb.push_back(e);
    endtask

    task automatic send_w(input logic [31:0] w);
        w_valid = 1'b1;
        w_data  = w;
        acc_m   = acc_m + fp_to_real(w);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic pulse();
        timestep = 1'b1;
        push_expect();
        tick();
        timestep = 1'b0;
        w_valid  = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        exp_t e;
        int   n = 0;
        while (done !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("input_weight", input_weight, e.iw);
            chk("decayed_potential", decayed_potential, e.dp);
            chk("spike_out", 32'(spike_out), 32'(e.spk));
            chk("potential", potential, e.pot);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        pot_m = 32'h0000_0000;
        acc_m = 0.0;
        sb.delete();
    endtask

    initial begin
        RESET = 1'b1; timestep = 1'b0; w_valid = 1'b0; w_data = 32'h0;
        ovr_en = 1'b0; ovr_val = 32'h0; pot_m = 32'h0; acc_m = 0.0;
        repeat (2) tick();
        RESET = 1'b0;
        tick();

        chk("rst_potential", potential, 32'h0000_0000);
        chk("rst_input_weight", input_weight, 32'h0);
        chk("rst_decayed", decayed_potential, 32'h0);
        chk("rst_w_ready", 32'(w_ready), 32'd1);
        chk("rst_set_clear", {30'd0, set_adder, clear_adder}, 32'd0);
        chk("rst_done_spike", {30'd0, done, spike_out}, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // 25.0 then 20.0 offered with the pulse: 45.0 -> spike, 5.0 left
        send_w(32'h41C8_0000);
        w_valid = 1'b1; w_data = 32'h41A0_0000; acc_m = acc_m + 20.0;
        pulse();
        wait_done(20);
        tick();

        // Latency and w_ready hold-off; a weight is offered throughout
        timestep = 1'b1;
        push_expect();
        tick();
        timestep = 1'b0;
        w_valid  = 1'b1;
        w_data   = 32'h3F80_0000;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) w_valid = 1'b0;
            chk($sformatf("lat_clear_%0d", i), 32'(clear_adder), 32'(i == 1));
            chk($sformatf("lat_set_%0d", i), 32'(set_adder), 32'(i == 2));
            chk($sformatf("lat_done_%0d", i), 32'(done), 32'(i == 7));
            chk($sformatf("lat_w_ready_%0d", i), 32'(w_ready), 32'd0);
            if (i < 7) tick();
        end
        wait_done(2);
        tick();

        // Exponent-1 potential, then infinity, then decay of infinity
        ovr_en = 1'b1; ovr_val = 32'h0080_0000;
        pulse();
        wait_done(20);
        tick();
        ovr_val = 32'h7F80_0000;
        pulse();
        wait_done(20);
        tick();
        ovr_en = 1'b0;
        pulse();
        wait_done(20);
        tick();

        do_reset();
        chk("rst2_potential", potential, 32'h0000_0000);

        // Three pulses in one timestep: two processed, third flags overrun
        send_w(32'h4248_0000);
        timestep = 1'b1;
        push_expect();
        tick();
        push_expect();
        tick();
        tick();
        timestep = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_done(20);
        tick();
        chk("back_to_back_busy", 32'(w_ready), 32'd0);
        wait_done(20);
        tick();
        chk("after_two_idle", 32'(w_ready), 32'd1);
        chk("after_two_no_done", 32'(done), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        do_reset();
        chk("overrun_cleared", 32'(overrun), 32'd0);

        // Reset during EVAL discards the accumulated weight
        send_w(32'h4120_0000);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        repeat (3) tick();
        chk("eval_input_weight", input_weight, 32'h4120_0000);
        do_reset();
        chk("abort_w_ready", 32'(w_ready), 32'd1);
        chk("abort_potential", potential, 32'h0000_0000);
        chk("abort_input_weight", input_weight, 32'h0);
        chk("abort_no_done", 32'(done), 32'd0);
        pulse();
        wait_done(20);
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
